// File: rtl/pipemem_stage.sv
// MEM stage of the 5-stage pipeline: data-memory access over a req/ack bus plus the MEM/WB register.
// Holds upstream stages with mem_stall while an access is outstanding; flags misalignment and timeout.
module pipemem_stage #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 5
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        mwreg,
   input  logic        mm2reg,
   input  logic        mwmem,
   input  logic [31:0] malu,
   input  logic [31:0] mb,
   input  logic [4:0]  mrn,
   output logic        mem_stall,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        wwreg,
   output logic        wm2reg,
   output logic [31:0] walu,
   output logic [31:0] wmo,
   output logic [4:0]  wrn,
   output logic [1:0]  err_code
);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               req_q, req_d, we_q, we_d;
   logic [31:0]        addr_q, addr_d, wdata_q, wdata_d;
   logic [31:0]        data_q, data_d;
   logic               tout_q, tout_d;
   logic               wwreg_q, wwreg_d, wm2reg_q, wm2reg_d;
   logic [31:0]        walu_q, walu_d, wmo_q, wmo_d;
   logic [4:0]         wrn_q, wrn_d;
   logic [1:0]         err_q, err_d;
   logic               memop, aligned, timeout_hit;

   assign memop       = mm2reg | mwmem;
   assign aligned     = (malu[1:0] == 2'b00);
   assign timeout_hit = (TIMEOUT != 0) && (32'(cnt_q) == TIMEOUT - 1);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      req_d     = req_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      data_d    = data_q;
      tout_d    = tout_q;
      wwreg_d   = wwreg_q;
      wm2reg_d  = wm2reg_q;
      walu_d    = walu_q;
      wmo_d     = wmo_q;
      wrn_d     = wrn_q;
      err_d     = err_q;
      mem_stall = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (memop && aligned) begin
               mem_stall = 1'b1;
               req_d     = 1'b1;
               we_d      = mwmem;
               addr_d    = malu;
               wdata_d   = mb;
               cnt_d     = '0;
               state_d   = StBusy;
            end else begin
               // A misaligned memop is squashed: no write-back, error flagged.
               wwreg_d  = memop ? 1'b0 : mwreg;
               wm2reg_d = memop ? 1'b0 : mm2reg;
               walu_d   = malu;
               wmo_d    = '0;
               wrn_d    = mrn;
               err_d    = memop ? 2'b01 : 2'b00;
            end
         end
         StBusy: begin
            mem_stall = 1'b1;
            cnt_d     = cnt_q + CNT_W'(1);
            if (dmem_ack) begin
               req_d   = 1'b0;
               data_d  = mwmem ? 32'd0 : dmem_rdata;
               tout_d  = 1'b0;
               state_d = StDone;
            end else if (timeout_hit) begin
               req_d   = 1'b0;
               data_d  = '0;
               tout_d  = 1'b1;
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
            walu_d  = malu;
            wrn_d   = mrn;
            if (tout_q) begin
               wwreg_d  = 1'b0;
               wm2reg_d = 1'b0;
               wmo_d    = '0;
               err_d    = 2'b10;
            end else begin
               wwreg_d  = mwreg;
               wm2reg_d = mm2reg;
               wmo_d    = data_q;
               err_d    = 2'b00;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         data_q   <= '0;
         tout_q   <= 1'b0;
         wwreg_q  <= 1'b0;
         wm2reg_q <= 1'b0;
         walu_q   <= '0;
         wmo_q    <= '0;
         wrn_q    <= '0;
         err_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         req_q    <= req_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         data_q   <= data_d;
         tout_q   <= tout_d;
         wwreg_q  <= wwreg_d;
         wm2reg_q <= wm2reg_d;
         walu_q   <= walu_d;
         wmo_q    <= wmo_d;
         wrn_q    <= wrn_d;
         err_q    <= err_d;
      end
   end

   assign dmem_req   = req_q;
   assign dmem_we    = we_q;
   assign dmem_addr  = addr_q;
   assign dmem_wdata = wdata_q;
   assign wwreg      = wwreg_q;
   assign wm2reg     = wm2reg_q;
   assign walu       = walu_q;
   assign wmo        = wmo_q;
   assign wrn        = wrn_q;
   assign err_code   = err_q;

endmodule
